// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token code words and alignment FSM states.
// Used by both the channel encoder and the channel decoder.
package tmds_pkg;

    // 10-bit TMDS control tokens, indexed by {C1,C0}
    localparam logic [9:0] CTL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTL_TOKEN_11 = 10'h2AB;

    // Word-alignment FSM encoding
    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // True when the word is one of the four control tokens
    function automatic logic is_ctl_token(input logic [9:0] q);
        return (q == CTL_TOKEN_00) || (q == CTL_TOKEN_01) ||
               (q == CTL_TOKEN_10) || (q == CTL_TOKEN_11);
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Per-channel TMDS receive bundle: raw deserialized word in, decoded video out.
interface tmds_channel_decoder_if;

    logic [9:0] RawWord;
    logic [7:0] Data;
    logic [1:0] Ctrl;
    logic       De;
    logic       Locked;
    logic [3:0] Offset;
    logic       LockLost;

    // Deserializer / bench side
    modport master (
        output RawWord,
        input  Data, Ctrl, De, Locked, Offset, LockLost
    );

    // Decoder side
    modport slave (
        input  RawWord,
        output Data, Ctrl, De, Locked, Offset, LockLost
    );

endinterface

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: one aligned 10-bit word to byte / control.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] q,
    output logic [7:0] Data,
    output logic [1:0] Ctrl,
    output logic       IsCtrl
);

    logic [7:0] w_d;

    // Undo the optional inversion, then undo the XOR/XNOR transition chain
    always_comb begin
        w_d     = q[9] ? ~q[7:0] : q[7:0];
        Data    = '0;
        Data[0] = w_d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            Data[i] = q[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    // Control-token recognition
    always_comb begin
        Ctrl   = '0;
        IsCtrl = 1'b1;
        case (q)
            CTL_TOKEN_00: Ctrl = 2'b00;
            CTL_TOKEN_01: Ctrl = 2'b01;
            CTL_TOKEN_10: Ctrl = 2'b10;
            CTL_TOKEN_11: Ctrl = 2'b11;
            default:      IsCtrl = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit-rotation gearbox, token-driven word alignment
// and registered decode to pixel byte / control bits / data enable.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned TOKEN_RUN     = 8,
    parameter int unsigned SEARCH_WINDOW = 2048,
    parameter int unsigned SLIP_SETTLE   = 4,
    parameter int unsigned LOCK_TIMEOUT  = 8192
) (
    input  logic                    PixelClk,
    input  logic                    Reset,
    tmds_channel_decoder_if.slave   bus
);

    localparam int unsigned RUN_W = $clog2(TOKEN_RUN) + 1;
    localparam int unsigned WIN_W = $clog2(SEARCH_WINDOW) + 1;
    localparam int unsigned SET_W = $clog2(SLIP_SETTLE) + 1;
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(TOKEN_RUN);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SLIP_SETTLE);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);

    // Gearbox
    logic [9:0]       r_raw_prev;
    logic [9:0]       r_align;
    logic [18:0]      w_cat;
    logic [9:0]       w_align_next;

    // Decode
    logic [7:0]       w_data;
    logic [1:0]       w_ctrl;
    logic             w_is_ctrl;
    logic [7:0]       r_data;
    logic [1:0]       r_ctrl;
    logic             r_de;

    // Alignment control
    logic [0:0]       r_state;
    logic [3:0]       r_offset;
    logic [WIN_W-1:0] r_window;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_next;
    logic [SET_W-1:0] r_settle;
    logic [TMO_W-1:0] r_timeout;
    logic             r_lock_lost;

    // RawWord[9] only ever lands in RawPrev; offsets 0..9 reach bit 18 at most
    assign w_cat = {bus.RawWord[8:0], r_raw_prev};

    // Select the 10-bit window starting at the current bit offset
    always_comb begin
        w_align_next = w_cat[9:0];
        case (r_offset)
            4'd0:    w_align_next = w_cat[9:0];
            4'd1:    w_align_next = w_cat[10:1];
            4'd2:    w_align_next = w_cat[11:2];
            4'd3:    w_align_next = w_cat[12:3];
            4'd4:    w_align_next = w_cat[13:4];
            4'd5:    w_align_next = w_cat[14:5];
            4'd6:    w_align_next = w_cat[15:6];
            4'd7:    w_align_next = w_cat[16:7];
            4'd8:    w_align_next = w_cat[17:8];
            4'd9:    w_align_next = w_cat[18:9];
            default: w_align_next = w_cat[9:0];
        endcase
    end

    // Gearbox stage: keep previous raw word and register the aligned word
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            r_raw_prev <= '0;
            r_align    <= '0;
        end else begin
            r_raw_prev <= bus.RawWord;
            r_align    <= w_align_next;
        end
    end

    tmds_word_decode u_decode (
        .q      (r_align),
        .Data   (w_data),
        .Ctrl   (w_ctrl),
        .IsCtrl (w_is_ctrl)
    );

    // Decode stage: tokens update Ctrl and hold Data, data words the reverse
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            r_data <= '0;
            r_ctrl <= '0;
            r_de   <= 1'b0;
        end else if (w_is_ctrl) begin
            r_ctrl <= w_ctrl;
            r_de   <= 1'b0;
        end else begin
            r_data <= w_data;
            r_de   <= 1'b1;
        end
    end

    // Consecutive-token run, saturating at the lock threshold
    always_comb begin
        w_run_next = '0;
        if (w_is_ctrl) begin
            w_run_next = (r_run == RUN_FULL) ? r_run : r_run + RUN_W'(1);
        end
    end

    // Alignment FSM: slip the offset until a token run is seen, then watch
    // for loss of tokens while locked
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            r_state     <= SEARCH;
            r_offset    <= '0;
            r_window    <= '0;
            r_run       <= '0;
            r_settle    <= '0;
            r_timeout   <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_lock_lost <= 1'b0;
            if (r_state == SEARCH) begin
                if (r_run == RUN_FULL) begin
                    // lock takes priority over a coincident window expiry
                    r_state   <= LOCKED;
                    r_timeout <= '0;
                    r_run     <= w_run_next;
                end else if (r_window == WIN_LAST) begin
                    r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    r_window <= '0;
                    r_run    <= '0;
                    r_settle <= SETTLE_INIT;
                end else begin
                    r_window <= r_window + WIN_W'(1);
                    // words in the pipeline still reflect the old offset
                    if (r_settle != '0) begin
                        r_settle <= r_settle - SET_W'(1);
                    end else begin
                        r_run <= w_run_next;
                    end
                end
            end else begin
                r_run <= w_run_next;
                if (w_is_ctrl) begin
                    r_timeout <= '0;
                end else if (r_timeout == TMO_LAST) begin
                    r_state     <= SEARCH;
                    r_lock_lost <= 1'b1;
                    r_window    <= '0;
                    r_run       <= '0;
                    r_timeout   <= '0;
                end else begin
                    r_timeout <= r_timeout + TMO_W'(1);
                end
            end
        end
    end

    assign bus.Data     = r_data;
    assign bus.Ctrl     = r_ctrl;
    assign bus.De       = r_de;
    assign bus.Locked   = (r_state == LOCKED);
    assign bus.Offset   = r_offset;
    assign bus.LockLost = r_lock_lost;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed alignment scenarios plus randomized
// data checked against a behavioural TMDS decode model.
module tb_tmds_channel_decoder;

    localparam int unsigned W      = 2048;
    localparam int unsigned RUN    = 8;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .TOKEN_RUN     (RUN),
        .SEARCH_WINDOW (W),
        .SLIP_SETTLE   (SETTLE),
        .LOCK_TIMEOUT  (TMO)
    ) dut (
        .PixelClk (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    logic [9:0] hist[$];
    logic [7:0] m_data;
    logic [1:0] m_ctrl;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference TMDS decode: token table, then data bit i = d[i] ^ d[i-1],
    // with bits 1..7 inverted when the word used the XNOR chain
    function automatic void ref_word(input logic [9:0] q, output bit tok,
                                     output logic [1:0] c, output logic [7:0] dat);
        logic [7:0] d;
        tok = 1'b1;
        c   = 2'b00;
        case (q)
            10'h354: c = 2'd0;
            10'h0AB: c = 2'd1;
            10'h154: c = 2'd2;
            10'h2AB: c = 2'd3;
            default: tok = 1'b0;
        endcase
        d   = q[9] ? ~q[7:0] : q[7:0];
        dat = d ^ {d[6:0], 1'b0};
        if (!q[8]) dat = dat ^ 8'hFE;
    endfunction

    function automatic bit is_tok(input logic [9:0] q);
        bit t; logic [1:0] c; logic [7:0] d;
        ref_word(q, t, c, d);
        return t;
    endfunction

    // Raw deserializer word when a repeated token's boundary lies 'phase'
    // bits into each captured word
    function automatic logic [9:0] serial_word(input logic [9:0] tok, input int unsigned phase);
        logic [9:0] r;
        for (int unsigned j = 0; j < 10; j++) r[j] = tok[(j + 10 - phase) % 10];
        return r;
    endfunction

    // Offset-0 step: apply a word and compare the word two cycles older
    task automatic step_aligned(input logic [9:0] w);
        bit tok; logic [1:0] c; logic [7:0] dd; logic [9:0] q;
        bus.RawWord = w;
        hist.push_back(w);
        tick();
        q = hist.pop_front();
        ref_word(q, tok, c, dd);
        if (tok) m_ctrl = c;
        else     m_data = dd;
        chk("de", {15'd0, bus.De}, {15'd0, !tok});
        chk("data", {8'd0, bus.Data}, {8'd0, m_data});
        chk("ctrl", {14'd0, bus.Ctrl}, {14'd0, m_ctrl});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"}, {8'd0, bus.Data}, 16'd0);
        chk({tag, "_ctrl"}, {14'd0, bus.Ctrl}, 16'd0);
        chk({tag, "_de"}, {15'd0, bus.De}, 16'd0);
        chk({tag, "_locked"}, {15'd0, bus.Locked}, 16'd0);
        chk({tag, "_offset"}, {12'd0, bus.Offset}, 16'd0);
        chk({tag, "_locklost"}, {15'd0, bus.LockLost}, 16'd0);
    endtask

    initial begin
        int          run_in;
        int          lock_at;
        int unsigned pulses;
        int unsigned slip3, lock3, lockw, rs_end;
        logic [9:0]  w;
        logic [9:0]  script[5];

        // ---- reset values ----
        bus.RawWord = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");

        // ---- aligned lock: 16 x 0x354 then 0x100 ----
        rst = 1'b0;
        hist = {10'h000, 10'h000};
        m_data = 8'h00;
        m_ctrl = 2'b00;
        run_in = 0;
        lock_at = -1;
        for (int i = 0; i < 17; i++) begin
            w = (i < 16) ? 10'h354 : 10'h100;
            run_in = is_tok(w) ? run_in + 1 : 0;
            if (run_in == int'(RUN) && lock_at < 0) lock_at = i + 3;
            step_aligned(w);
            chk("lock_aligned", {15'd0, bus.Locked}, {15'd0, (lock_at >= 0 && i >= lock_at)});
        end
        chk("offset_aligned", {12'd0, bus.Offset}, 16'd0);

        // ---- data decode after lock, then randomized words ----
        script = '{10'h0FF, 10'h3FF, 10'h100, 10'h2AB, 10'h0FF};
        foreach (script[k]) step_aligned(script[k]);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       w = 10'h354;
                    1:       w = 10'h0AB;
                    2:       w = 10'h154;
                    default: w = 10'h2AB;
                endcase
            end else begin
                w = 10'($urandom_range(0, 1023));
            end
            step_aligned(w);
        end
        chk("locked_after_random", {15'd0, bus.Locked}, 16'd1);
        chk("offset_after_random", {12'd0, bus.Offset}, 16'd0);

        // ---- broken run: 7 tokens, 1 data, 7 tokens, data, then 12 tokens ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_in = 0;
        lock_at = -1;
        for (int i = 0; i < 37; i++) begin
            if (i < 7)       w = 10'h354;
            else if (i == 7) w = 10'h100;
            else if (i < 15) w = 10'h354;
            else if (i < 25) w = 10'h100;
            else             w = 10'h354;
            run_in = is_tok(w) ? run_in + 1 : 0;
            if (run_in == int'(RUN) && lock_at < 0) lock_at = i + 3;
            bus.RawWord = w;
            tick();
            chk("lock_broken", {15'd0, bus.Locked}, {15'd0, (lock_at >= 0 && i >= lock_at)});
        end

        // ---- lock loss after LOCK_TIMEOUT non-token words ----
        pulses = 0;
        for (int k = 0; k < int'(TMO) + 8; k++) begin
            bus.RawWord = 10'h100;
            tick();
            if (bus.LockLost) pulses++;
            if (k == int'(TMO)) begin
                chk("still_locked", {15'd0, bus.Locked}, 16'd1);
                chk("no_early_loss", {15'd0, bus.LockLost}, 16'd0);
            end
            if (k == int'(TMO) + 1) begin
                chk("locklost_pulse", {15'd0, bus.LockLost}, 16'd1);
                chk("unlocked", {15'd0, bus.Locked}, 16'd0);
                chk("offset_kept", {12'd0, bus.Offset}, 16'd0);
            end
        end
        chk("locklost_count", 16'(pulses), 16'd1);

        // ---- relock without slip ----
        for (int m = 0; m < 12; m++) begin
            bus.RawWord = 10'h354;
            tick();
            if (m == int'(RUN) + 1) chk("relock_pending", {15'd0, bus.Locked}, 16'd0);
            if (m == int'(RUN) + 2) chk("relock", {15'd0, bus.Locked}, 16'd1);
        end
        chk("relock_offset", {12'd0, bus.Offset}, 16'd0);

        // ---- misalignment: boundary 3 bits into each word, token 0x0AB ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        slip3 = 3 * W - 1;
        lock3 = slip3 + SETTLE + RUN + 1;
        for (int unsigned i = 0; i <= lock3 + 4; i++) begin
            bus.RawWord = serial_word(10'h0AB, 3);
            tick();
            if (i == W - 2)     chk("offset_before_slip", {12'd0, bus.Offset}, 16'd0);
            if (i == W - 1)     chk("offset_slip1", {12'd0, bus.Offset}, 16'd1);
            if (i == 2 * W - 1) chk("offset_slip2", {12'd0, bus.Offset}, 16'd2);
            if (i == slip3)     chk("offset_slip3", {12'd0, bus.Offset}, 16'd3);
            if (i == lock3 - 1) chk("misalign_prelock", {15'd0, bus.Locked}, 16'd0);
            if (i == lock3) begin
                chk("misalign_lock", {15'd0, bus.Locked}, 16'd1);
                chk("misalign_offset", {12'd0, bus.Offset}, 16'd3);
            end
            if (i == lock3 + 4) begin
                chk("misalign_ctrl", {14'd0, bus.Ctrl}, 16'd1);
                chk("misalign_de", {15'd0, bus.De}, 16'd0);
            end
        end

        // ---- offset wrap 9 -> 0 ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lockw = 10 * W - 1 + SETTLE + RUN + 1;
        for (int unsigned i = 0; i <= lockw; i++) begin
            bus.RawWord = (i < 9 * W) ? 10'h100 : 10'h354;
            tick();
            if (i == 9 * W - 1)  chk("offset_nine", {12'd0, bus.Offset}, 16'd9);
            if (i == 10 * W - 2) chk("wrap_nolock", {15'd0, bus.Locked}, 16'd0);
            if (i == 10 * W - 1) chk("offset_wrap", {12'd0, bus.Offset}, 16'd0);
            if (i == lockw - 1)  chk("wrap_prelock", {15'd0, bus.Locked}, 16'd0);
            if (i == lockw)      chk("wrap_lock", {15'd0, bus.Locked}, 16'd1);
        end

        // ---- reset mid-search at offset 5, half window elapsed ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs_end = 5 * W - 1 + W / 2;
        for (int unsigned i = 0; i <= rs_end; i++) begin
            bus.RawWord = 10'h0FF;
            tick();
            if (i == 5 * W - 1) chk("offset_five", {12'd0, bus.Offset}, 16'd5);
        end
        chk("pre_reset_de", {15'd0, bus.De}, 16'd1);
        rst = 1'b1;
        tick();
        chk_reset_state("midreset");
        rst = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            bus.RawWord = 10'h0FF;
            tick();
            if (i == W - 2) chk("restart_full_window", {12'd0, bus.Offset}, 16'd0);
            if (i == W - 1) chk("restart_slip", {12'd0, bus.Offset}, 16'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the DVI/HDMI TMDS output path. Handles one TMDS channel.
- Accepts raw 10-bit words from a 1:10 deserializer running on PixelClk.
- Finds the word boundary with an internal bit-rotation gearbox driven by control-token detection.
- Decodes the aligned words to 8-bit pixel data, 2-bit control and a data-enable flag.
- Sits between the ISERDES capture logic and the video timing recovery; three instances are used per link.

Parameters:
- TOKEN_RUN, 8: consecutive control tokens required to declare lock.
- SEARCH_WINDOW, 2048: PixelClk cycles spent at one bit offset before slipping.
- SLIP_SETTLE, 4: cycles after an offset change during which token counting is suppressed. Minimum 2.
- LOCK_TIMEOUT, 8192: cycles without any control token before lock is declared lost.

Ports:
- PixelClk  in  1  pixel-rate clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- RawWord  in  10  deserialized word; bit 0 is the earliest received bit.
- Data  out  8  decoded pixel byte.
- Ctrl  out  2  decoded control bits {C1,C0}; hold their last token value during data periods.
- De  out  1  1 = data period, 0 = control token.
- Locked  out  1  word alignment valid.
- Offset  out  4  current bit-rotation offset, 0..9.
- LockLost  out  1  one-cycle pulse when Locked falls due to timeout.

Behaviour:
- Interface: one clock (PixelClk); reset (Reset) is synchronous and active-high.
- Reset values: Data=0, Ctrl=0, De=0, Locked=0, Offset=0, LockLost=0. Internal RawPrev=0, AlignWord=0. All counters 0. State=SEARCH.
- Reset asserted mid-operation returns everything to these values on the next edge, regardless of state.
- Gearbox (stage 1):
  - RawPrev <= RawWord each cycle.
  - AlignWord <= {RawWord, RawPrev}[Offset +: 10].
  - With Offset=0, AlignWord equals the word presented one cycle earlier.
- Decode (stage 2), registered from AlignWord = q:
  - Control tokens: q==0x354 -> Ctrl=00; 0x0AB -> 01; 0x154 -> 10; 0x2AB -> 11. For each, De=0 and Data is held.
  - Any other q: De=1 and Ctrl is held.
  - d = q[9] ? ~q[7:0] : q[7:0].
  - Data[0] = d[0].
  - Data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
- Latency: a word sampled at edge n appears on Data/Ctrl/De after edge n+2 (stable offset).
- Decoding runs in all states; outputs are meaningful only while Locked=1.
- Token run counter:
  - Increments when AlignWord is any control token; clears on any non-token word.
  - Saturates at TOKEN_RUN.
- FSM state SEARCH:
  - Window counter increments every cycle. The token run counts only when the settle counter is 0.
  - Run reaches TOKEN_RUN -> go to LOCKED; Locked=1 on the following edge.
  - Otherwise, when the window counter reaches SEARCH_WINDOW-1:
    - Offset <= (Offset==9) ? 0 : Offset+1.
    - Window counter cleared, run cleared, settle counter <= SLIP_SETTLE.
  - If lock and window expiry occur in the same cycle, lock wins and there is no slip.
- FSM state LOCKED:
  - Offset is frozen.
  - Timeout counter clears on any control token and otherwise increments.
  - Timeout reaching LOCK_TIMEOUT-1 -> LockLost=1 for one cycle, Locked=0, go to SEARCH.
  - On this transition, window counter and run are cleared and Offset is kept. The first slip comes only after a full window.
- Counter widths: $clog2 of the respective parameter + 1. No wrap in LOCKED because the counter clears on exit.

Decomposition:
- Shared package tmds_pkg:
  - The four control-token constants (CTL_TOKEN_00/01/10/11).
  - The FSM state encoding (SEARCH, LOCKED).
  - Both are reused by the encoder side.
- One combinational sub-module, tmds_word_decode: q[9:0] in -> Data, Ctrl, IsCtrl out. Gearbox, counters and FSM stay in the top module.

Test Plan:
- Aligned lock: Offset already correct; 16×0x354 then 0x100 -> Locked=1 on the edge after the 8th token reaches the counter. Ctrl=00, De=0 during tokens. Offset stays 0.
- Misalignment: serial stream rotated so the correct offset is 3, repeating 0x0AB -> Offset steps 0→1→2→3, one step every 2048 cycles, then Locked=1 with Offset=3 and Ctrl=01. Wrap check: correct offset 0 with start forced to 9 gives 9→0.
- Data decode after lock: 0x0FF -> Data=0xFF, 0x3FF -> Data=0x00, 0x100 -> Data=0x00, each with De=1, exactly 2 cycles after input. Ctrl keeps its last token value.
- Broken run: 7×0x354, 1×0x100, 7×0x354 -> no lock. Run restarts; lock only after 8 uninterrupted tokens.
- Lock loss: locked, then 8192 data words -> single-cycle LockLost pulse, Locked=0, Offset unchanged. Relock on the next 8 tokens without a slip.
- Reset mid-search at Offset=5, window half elapsed -> next edge Offset=0, Locked=0, Data=0, De=0. Search restarts from a full window.
